sg_read_req_gen: RTL
====================

SG_READ_REQ_GEN -- requirements
Module: sg_read_req_gen

Interface
REQ-001 SHALL have parameter C_MAX_READ_REQ, default 2, hard cap on read request size code (0=128B … 5=4096B).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rRst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port CONFIG_MAX_READ_REQUEST_SIZE  input  3  link max read request code (0..5).
REQ-005 SHALL have port SG_ELEM_ADDR  input  64  scatter-gather element byte address, dword aligned.
REQ-006 SHALL have port SG_ELEM_LEN  input  32  element length in bytes, multiple of 4.
REQ-007 SHALL have port SG_ELEM_RDY  input  1  element valid at SG_ELEM_ADDR/LEN.
REQ-008 SHALL have port SG_ELEM_REN  output  1  one-cycle pulse consuming the presented element.
REQ-009 SHALL have port RX_REQ  output  1  read request valid.
REQ-010 SHALL have port RX_REQ_ACK  input  1  request accepted by the engine.
REQ-011 SHALL have port RX_REQ_TAG  output  2  tag of current request.
REQ-012 SHALL have port RX_REQ_ADDR  output  64  request byte address.
REQ-013 SHALL have port RX_REQ_LEN  output  10  request length in dwords; 1024 encoded as 0.
REQ-014 SHALL have port TAG_DONE  input  1  pulse: completion for tag TAG_DONE_ID fully received.
REQ-015 SHALL have port TAG_DONE_ID  input  2  tag being released.
REQ-016 SHALL have port WORDS_ISSUED  output  32  running count of dwords acknowledged since reset.
REQ-017 SHALL have port IDLE  output  1  high in IDLE state with no tags outstanding.

Function
REQ-018 SHALL implement states IDLE, FETCH, CALC, WAIT_TAG, REQ.
REQ-019 IDLE: when SG_ELEM_RDY=1, SHALL assert SG_ELEM_REN for exactly one cycle, latch ADDR/LEN, go to FETCH.
REQ-020 FETCH: zero latched length SHALL return to IDLE with no request; otherwise go to CALC.
REQ-021 CALC SHALL register chunk bytes = min(remaining, maxBytes, 4096 - addr[11:0]), maxBytes = 128 << min(CONFIG_MAX_READ_REQUEST_SIZE, C_MAX_READ_REQ); config codes >5 treated as 5.
REQ-022 CALC SHALL go to REQ if a tag is free, else WAIT_TAG; WAIT_TAG SHALL go to REQ the cycle after any tag becomes free.
REQ-023 Entering REQ SHALL allocate the lowest-numbered free tag at or after the round-robin pointer (pointer starts at 0, advances to allocated tag + 1 mod 4).
REQ-024 REQ: RX_REQ SHALL stay high with TAG/ADDR/LEN stable until the cycle RX_REQ_ACK=1; RX_REQ SHALL drop the following cycle.
REQ-025 On ACK: addr += chunk, remaining -= chunk, WORDS_ISSUED += chunk/4 (wraps mod 2^32), tag marked outstanding; next state CALC if remaining > 0, else IDLE.
REQ-026 RX_REQ_ACK while RX_REQ=0 SHALL be ignored.
REQ-027 TAG_DONE SHALL clear the outstanding bit of TAG_DONE_ID; release of a non-outstanding tag SHALL be ignored.
REQ-028 TAG_DONE in the same cycle as allocation of a different tag SHALL apply both; the released tag is allocatable from the next cycle.
REQ-029 At most 4 requests SHALL be outstanding; no request issued with all tags outstanding.
REQ-030 Address arithmetic SHALL be full 64-bit with carry into the upper 32 bits; no request SHALL cross a 4 KB boundary.
REQ-031 SG_ELEM_REN SHALL never assert outside IDLE; a new element is fetched only after the previous element is fully issued.

Reset
REQ-032 While rRst=1: state IDLE, SG_ELEM_REN=0, RX_REQ=0, RX_REQ_TAG=0, RX_REQ_ADDR=0, RX_REQ_LEN=0, WORDS_ISSUED=0, all tags free, round-robin pointer 0, IDLE=1.
REQ-033 rRst asserted mid-request SHALL drop RX_REQ immediately and discard outstanding tags and the partial element.

Verification
REQ-034 C_MAX_READ_REQ=2, config=2, elem addr 0x1000 len 2048 -> four requests, LEN 128, addrs 0x1000/0x1200/0x1400/0x1600, tags 0,1,2,3, WORDS_ISSUED=512.
REQ-035 Elem addr 0x0F80 len 512, max 512B -> requests 0x0F80 len 32, then 0x1000 len 96 (4 KB split).
REQ-036 Five-chunk element, no TAG_DONE -> four requests then RX_REQ stays low; TAG_DONE_ID=1 pulse -> fifth request issues with tag 1.
REQ-037 Elem len 0 -> one SG_ELEM_REN pulse, no RX_REQ, return to IDLE.
REQ-038 C_MAX_READ_REQ=5, config=5, addr 0x2000 len 4096 -> one request RX_REQ_LEN=0 (1024 dwords); config=1 same element -> sixteen 256B requests.
REQ-039 Hold RX_REQ_ACK low 10 cycles -> RX_REQ/ADDR/LEN/TAG stable; assert rRst mid-wait -> RX_REQ=0 next edge, IDLE=1, WORDS_ISSUED=0.

Source files
------------

// File: rtl/sg_read_req_gen_if.sv
// Handshake and bus bundle between the scatter-gather read request generator
// and its element source / read engine.
interface sg_read_req_gen_if;
    logic [63:0] elem_addr;
    logic [31:0] elem_len;
    logic        elem_rdy;
    logic        elem_ren;
    logic        req;
    logic        req_ack;
    logic [1:0]  req_tag;
    logic [63:0] req_addr;
    logic [9:0]  req_len;
    logic        tag_done;
    logic [1:0]  tag_done_id;
    logic [31:0] words_issued;
    logic        idle;

    modport master (
        input  elem_addr, elem_len, elem_rdy, req_ack, tag_done, tag_done_id,
        output elem_ren, req, req_tag, req_addr, req_len, words_issued, idle
    );

    modport slave (
        output elem_addr, elem_len, elem_rdy, req_ack, tag_done, tag_done_id,
        input  elem_ren, req, req_tag, req_addr, req_len, words_issued, idle
    );
endinterface

// File: rtl/sg_read_req_gen.sv
// Splits scatter-gather elements into read requests bounded by the max read
// request size and 4 KB pages, tracking up to four outstanding tags.
module sg_read_req_gen #(
    parameter int unsigned C_MAX_READ_REQ = 2
) (
    input  logic        CLK,
    input  logic        rRst,
    input  logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE,
    input  logic [63:0] SG_ELEM_ADDR,
    input  logic [31:0] SG_ELEM_LEN,
    input  logic        SG_ELEM_RDY,
    output logic        SG_ELEM_REN,
    output logic        RX_REQ,
    input  logic        RX_REQ_ACK,
    output logic [1:0]  RX_REQ_TAG,
    output logic [63:0] RX_REQ_ADDR,
    output logic [9:0]  RX_REQ_LEN,
    input  logic        TAG_DONE,
    input  logic [1:0]  TAG_DONE_ID,
    output logic [31:0] WORDS_ISSUED,
    output logic        IDLE
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CALC, S_WAIT_TAG, S_REQ} state_t;

    localparam logic [2:0] CAP_CODE = (C_MAX_READ_REQ > 5) ? 3'd5 : 3'(C_MAX_READ_REQ);

    state_t      state_q;
    logic [63:0] addr_q;
    logic [31:0] rem_q;
    logic [12:0] chunk_q;
    logic [3:0]  busy_q;
    logic [3:0]  busy_d;
    logic [1:0]  rr_q;
    logic        req_q;
    logic [1:0]  tag_q;
    logic [63:0] req_addr_q;
    logic [9:0]  req_len_q;
    logic [31:0] words_q;

    logic [2:0]  cfg_code;
    logic [12:0] max_bytes;
    logic [12:0] to_bound;
    logic [12:0] chunk_d;
    logic        tag_free;
    logic [1:0]  free_tag;
    logic [1:0]  cand;
    logic        ack;
    logic [31:0] rem_after;

    always_comb begin
        cfg_code = CONFIG_MAX_READ_REQUEST_SIZE;
        if (cfg_code > 3'd5) cfg_code = 3'd5;
        if (cfg_code > CAP_CODE) cfg_code = CAP_CODE;
        max_bytes = 13'd128 << cfg_code;
        to_bound  = 13'h1000 - {1'b0, addr_q[11:0]};
        chunk_d   = max_bytes;
        if (to_bound < chunk_d) chunk_d = to_bound;
        if (rem_q < {19'b0, chunk_d}) chunk_d = rem_q[12:0];
    end

    // Round-robin search: first free tag at or after the pointer.
    always_comb begin
        tag_free = 1'b0;
        free_tag = rr_q;
        cand     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!tag_free && !busy_q[cand]) begin
                tag_free = 1'b1;
                free_tag = cand;
            end
        end
    end

    assign ack       = RX_REQ_ACK && req_q;
    assign rem_after = rem_q - {19'b0, chunk_q};

    // Release is applied before the ack set; a just-allocated tag is never busy.
    always_comb begin
        busy_d = busy_q;
        if (TAG_DONE) busy_d[TAG_DONE_ID] = 1'b0;
        if (ack) busy_d[tag_q] = 1'b1;
    end

    always_ff @(posedge CLK or posedge rRst) begin
        if (rRst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            chunk_q    <= '0;
            busy_q     <= '0;
            rr_q       <= '0;
            req_q      <= 1'b0;
            tag_q      <= '0;
            req_addr_q <= '0;
            req_len_q  <= '0;
            words_q    <= '0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                S_IDLE: begin
                    if (SG_ELEM_RDY) begin
                        addr_q  <= SG_ELEM_ADDR;
                        rem_q   <= SG_ELEM_LEN;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= (rem_q == '0) ? S_IDLE : S_CALC;
                S_CALC: begin
                    chunk_q <= chunk_d;
                    if (tag_free) begin
                        state_q    <= S_REQ;
                        req_q      <= 1'b1;
                        tag_q      <= free_tag;
                        rr_q       <= free_tag + 2'd1;
                        req_addr_q <= addr_q;
                        req_len_q  <= chunk_d[11:2];
                    end else begin
                        state_q <= S_WAIT_TAG;
                    end
                end
                S_WAIT_TAG: begin
                    if (tag_free) begin
                        state_q    <= S_REQ;
                        req_q      <= 1'b1;
                        tag_q      <= free_tag;
                        rr_q       <= free_tag + 2'd1;
                        req_addr_q <= addr_q;
                        req_len_q  <= chunk_q[11:2];
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        req_q   <= 1'b0;
                        addr_q  <= addr_q + {51'b0, chunk_q};
                        rem_q   <= rem_after;
                        words_q <= words_q + {21'b0, chunk_q[12:2]};
                        state_q <= (rem_after != '0) ? S_CALC : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SG_ELEM_REN  = !rRst && (state_q == S_IDLE) && SG_ELEM_RDY;
    assign RX_REQ       = req_q;
    assign RX_REQ_TAG   = tag_q;
    assign RX_REQ_ADDR  = req_addr_q;
    assign RX_REQ_LEN   = req_len_q;
    assign WORDS_ISSUED = words_q;
    assign IDLE         = (state_q == S_IDLE) && (busy_q == '0);
endmodule
